// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start-bit qualification, mid-bit data sampling,
// stop-bit check and a one-clock done strobe.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_TICKS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rate,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done_tick,
  output logic                 frame_error
);

  localparam int unsigned SW = (STOP_TICKS > 16) ? 8 : 4;
  localparam int unsigned NW = 3;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_meta_q, rx_s_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;

    unique case (state_q)
      // Start detection does not wait for a tick.
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (rate) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (rate) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DATA_BITS-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (rate) begin
          if (s_q == S_STOP) begin
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_error  = ferr_q;

endmodule
